// File: rtl/dmem_wbuf.sv
// dmem_wbuf: data-memory responder with a posted-write buffer.
// Stores go into a circular FIFO and drain into a single-port word RAM
// whenever no load is in progress. Loads read combinationally, and a
// matching buffered store takes priority over the RAM word.
// Optional build macro WBUF_COALESCE_EN: a store that hits a buffered word
// overwrites that entry in place instead of enqueueing a new one.

// Per-entry address comparator, one instance per buffer slot.
module dmem_wbuf_cmp #(
  parameter int ADDR_BITS = 6
) (
  input  logic                 vld,
  input  logic [ADDR_BITS-1:0] eidx,
  input  logic [ADDR_BITS-1:0] widx,
  output logic                 hit
);
  assign hit = vld & (eidx == widx);
endmodule

module dmem_wbuf #(
  parameter int ADDR_BITS  = 6,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        memwrite,
  input  logic                        memread,
  input  logic [31:0]                 aluout,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic                        stall,
  output logic [$clog2(WBUF_DEPTH):0] wbuf_count,
  output logic                        wbuf_empty
);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_BITS-1:0] idx;
    logic [31:0]          data;
  } ent_t;

  ent_t                  wb  [WBUF_DEPTH];
  logic [31:0]           mem [2**ADDR_BITS];
  logic [PW-1:0]         head, tail, hslot, scan;
  logic [CW-1:0]         count;
  logic [ADDR_BITS-1:0]  widx;
  logic [WBUF_DEPTH-1:0] vld, hit;
  logic                  full, drain, enq, push, coal, anyhit;
  logic [31:0]           fwd, ram_wdata;
  logic                  unused;

  // Offset bits and bits above the RAM index are don't-care (address wraps).
  assign widx   = aluout[ADDR_BITS+1:2];
  assign unused = ^{aluout[1:0], aluout[31:ADDR_BITS+2]};

  assign full  = (count == CW'(WBUF_DEPTH));
  assign drain = ~memread & (count != '0);
  assign enq   = memwrite & ~stall;

  // Slot validity comes from its age relative to head, not pointer equality.
  generate
    for (genvar i = 0; i < WBUF_DEPTH; i++) begin : g_ent
      logic [PW-1:0] age;
      assign age    = PW'(i) - head;
      assign vld[i] = ({1'b0, age} < count);
      dmem_wbuf_cmp #(.ADDR_BITS(ADDR_BITS)) u_cmp (
        .vld  (vld[i]),
        .eidx (wb[i].idx),
        .widx (widx),
        .hit  (hit[i])
      );
    end
  endgenerate

  // Walk slots oldest to youngest so the last match found is the youngest.
  always_comb begin
    anyhit = 1'b0;
    hslot  = '0;
    fwd    = '0;
    scan   = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      scan = head + PW'(k);
      if (hit[scan]) begin
        anyhit = 1'b1;
        hslot  = scan;
        fwd    = wb[scan].data;
      end
    end
  end

  assign readdata = anyhit ? fwd : mem[widx];

`ifdef WBUF_COALESCE_EN
  assign stall = memwrite & full & ~anyhit;
  assign push  = enq & ~anyhit;
  assign coal  = enq & anyhit;
`else
  assign stall = memwrite & full;
  assign push  = enq;
  assign coal  = 1'b0;
`endif

  // A coalescing store onto the entry draining this edge goes straight to RAM.
  assign ram_wdata = (coal && hslot == head) ? writedata : wb[head].data;

  assign wbuf_count = count;
  assign wbuf_empty = (count == '0);

  // Pointer/occupancy state; reset drops every pending entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)  tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      count <= count + CW'(push) - CW'(drain);
    end
  end

  // Buffer payload storage; validity is owned by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) wb[tail]       <= {widx, writedata};
    if (coal) wb[hslot].data <= writedata;
  end

  // Word RAM, written only by the drain of the head entry.
  always_ff @(posedge clk) begin
    if (drain) mem[wb[head].idx] <= ram_wdata;
  end
endmodule

// File: tb/tb_dmem_wbuf.sv
// tb_dmem_wbuf: directed plus random stimulus against a queue-based model
// of the posted-write buffer and a flat word array for the RAM.
module tb_dmem_wbuf;
  localparam int AB = 6;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;
  localparam int NW = 2**AB;

  logic          clk = 1'b0, reset = 1'b0, memwrite = 1'b0, memread = 1'b0;
  logic [31:0]   aluout = '0, writedata = '0, readdata;
  logic          stall, wbuf_empty;
  logic [CW-1:0] wbuf_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned idx;
    logic [31:0] d;
  } ment_t;

  ment_t       q[$];
  logic [31:0] ram_m [NW];
  bit          known [NW];
  logic        last_stall = 1'b0;

  dmem_wbuf #(.ADDR_BITS(AB), .WBUF_DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .memread    (memread),
    .aluout     (aluout),
    .writedata  (writedata),
    .readdata   (readdata),
    .stall      (stall),
    .wbuf_count (wbuf_count),
    .wbuf_empty (wbuf_empty)
  );

  always #5 clk = ~clk;

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % NW;
  endfunction

  function automatic int find(input int unsigned w);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].idx == w) return i;
    return -1;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    int h;
    h = find(widx(a));
    if (h >= 0) return q[h].d;
    return ram_m[widx(a)];
  endfunction

  function automatic logic exp_stall(input logic mw, input logic [31:0] a);
`ifdef WBUF_COALESCE_EN
    return mw && q.size() == D && find(widx(a)) < 0;
`else
    return mw && q.size() == D && a == a;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input logic mw, input logic mr, input logic [31:0] a, input logic [31:0] wd);
    logic st;
    bit   drn, hitc;
    memwrite = mw; memread = mr; aluout = a; writedata = wd;
    @(negedge clk);
    st = exp_stall(mw, a);
    if (find(widx(a)) >= 0 || known[widx(a)]) chk("readdata", readdata, exp_rd(a));
    chk("stall", 32'(stall), 32'(st));
    chk("count", 32'(wbuf_count), 32'(q.size()));
    chk("empty", 32'(wbuf_empty), 32'(q.size() == 0));
    last_stall = st;
    @(posedge clk); #1;
    drn  = !mr && q.size() > 0;
    hitc = 1'b0;
`ifdef WBUF_COALESCE_EN
    if (mw && !st) begin
      int h;
      h = find(widx(a));
      if (h >= 0) begin q[h].d = wd; hitc = 1'b1; end
    end
`endif
    if (drn) begin
      ram_m[q[0].idx] = q[0].d;
      known[q[0].idx] = 1'b1;
      void'(q.pop_front());
    end
    if (mw && !st && !hitc) q.push_back('{idx: widx(a), d: wd});
  endtask

  // Core-style store: hold the request until accepted, bounded.
  task automatic store_hold(input logic mr, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    step(1'b1, mr, a, wd);
    while (last_stall && n < 20) begin
      step(1'b1, 1'b0, a, wd);
      n++;
    end
    if (last_stall) begin
      checks++; errors++;
      $error("FAIL store_hold: store at %08h never accepted", a);
    end
  endtask

  task automatic drain_all();
    for (int i = 0; i < D + 2; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic        mw, mr;
    logic [31:0] a, wd;
    for (int i = 0; i < NW; i++) begin ram_m[i] = '0; known[i] = 1'b0; end

    // Reset with a store request present: nothing may be buffered.
    reset = 1'b0; memwrite = 1'b1; aluout = 32'h4;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(wbuf_count), 32'd0);
    chk("rst_empty", 32'(wbuf_empty), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    memwrite = 1'b0;
    reset = 1'b1;

    // Give every RAM word a known value.
    for (int i = 0; i < NW; i++) step(1'b1, 1'b0, 32'(i * 4), $urandom);
    step(1'b0, 1'b0, 32'h0, 32'h0);

    // Plain load reads RAM.
    step(1'b0, 1'b1, 32'h10, 32'h0);
    step(1'b0, 1'b1, 32'h10, 32'h0);

    // Forwarding, then drain with no visibility gap.
    step(1'b1, 1'b0, 32'h20, 32'hDEADBEEF);
    step(1'b0, 1'b1, 32'h20, 32'h0);
    step(1'b0, 1'b0, 32'h20, 32'h0);
    step(1'b0, 1'b1, 32'h20, 32'h0);
    chk("ram8", ram_m[8], 32'hDEADBEEF);

    // Fill to depth under memread, fifth store stalls until a drain.
    for (int i = 0; i < D; i++) step(1'b1, 1'b1, 32'(i * 4), 32'h1000 + 32'(i));
    step(1'b1, 1'b1, 32'h10, 32'h1004);
    chk("full_stall", 32'(stall), 32'd1);
    store_hold(1'b0, 32'h10, 32'h1004);
    drain_all();
    for (int i = 0; i <= D; i++) step(1'b0, 1'b1, 32'(i * 4), 32'h0);

    // Two stores to one word: youngest forwarded, youngest lands in RAM.
    step(1'b1, 1'b1, 32'h40, 32'h1);
    step(1'b1, 1'b1, 32'h40, 32'h2);
    step(1'b0, 1'b1, 32'h40, 32'h0);
    drain_all();
    chk("ram16", ram_m[16], 32'h2);

    // Address wrap and ignored offset bits.
    step(1'b1, 1'b0, 32'h100, 32'hA5);
    step(1'b0, 1'b1, 32'h000, 32'h0);
    step(1'b0, 1'b1, 32'h103, 32'h0);
    drain_all();
    step(1'b0, 1'b1, 32'h103, 32'h0);

    // Async reset discards pending stores; RAM keeps old words.
    step(1'b1, 1'b1, 32'h30, $urandom);
    step(1'b1, 1'b1, 32'h34, $urandom);
    step(1'b1, 1'b1, 32'h38, $urandom);
    memwrite = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_count", 32'(wbuf_count), 32'd0);
    chk("arst_empty", 32'(wbuf_empty), 32'd1);
    q.delete();
    #1;
    reset = 1'b1;
    step(1'b0, 1'b1, 32'h30, 32'h0);
    step(1'b0, 1'b1, 32'h34, 32'h0);
    step(1'b0, 1'b0, 32'h38, 32'h0);

    // Random traffic over a few hot words; a stalled store is held.
    mw = 1'b0; a = '0; wd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        mw = 1'($urandom_range(0, 1));
        a  = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
        wd = $urandom;
      end
      mr = 1'($urandom_range(0, 1));
      step(mw, mr, a, wd);
    end
    drain_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time bound so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
